hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
// Pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB). Watches the ID-stage decode
// outputs and the register-writing state of EX/MEM/WB. Produces stall, bubble and flush
// controls, and registered operand-forwarding selects. Also runs the illegal-instruction
// trap sequence: drain older instructions, then redirect fetch to TRAP_VECTOR.
// PARAMETERS
// DRAIN_CYCLES  2             cycles of non-stalled drain before the trap redirect (>=1)
// TRAP_VECTOR   32'h0000_0010 fetch address driven on trap_pc during redirect
// PORTS
// clk              in   1   core clock
// reset            in   1   synchronous, active-high
// id_valid         in   1   ID stage holds a real instruction
// id_rs1, id_rs2   in   5   source registers from decode
// id_illegal       in   1   decode illegal_op
// ex_valid         in   1   EX instruction valid
// ex_rd            in   5   EX destination register
// ex_write_reg     in   1   EX instruction writes a register
// ex_is_load       in   1   EX instruction is a load (mem_read != 0)
// ex_branch_taken  in   1   EX resolved a taken branch or jump
// mem_valid, mem_write_reg  in 1   MEM stage validity and register write
// mem_rd           in   5   MEM destination register
// mem_busy         in   1   data memory not ready; the whole pipe must hold
// stall_front      out  1   hold the PC, IF/ID register and the ID stage
// stall_back       out  1   hold the EX/MEM and MEM/WB registers
// bubble_ex        out  1   load a NOP (control = 0) into ID/EX
// flush_front      out  1   invalidate IF and ID contents
// fwd1_sel, fwd2_sel out 2  registered, aligned with the instruction in EX:
//                           0 = REG, 1 = MEM, 2 = WB
// trap_redirect    out  1   one-cycle pulse; fetch loads trap_pc
// trap_pc          out  32  TRAP_VECTOR while trap_redirect = 1, else 0
// BEHAVIOUR
// - Reset: state = RUN, drain counter = 0, fwd*_sel = REG. All control outputs are 0
//   during reset and in the first cycle after it.
// - Reset asserted in any state aborts that state. No trap_redirect is issued afterwards.
// - States and transitions:
//   RUN -> DRAIN when id_illegal & id_valid & !ex_branch_taken & !mem_busy.
//   DRAIN -> REDIRECT when the drain counter = DRAIN_CYCLES-1 and !mem_busy.
//   REDIRECT -> RUN, unconditionally.
// - RUN, priority high to low:
//   1) mem_busy: stall_front = stall_back = 1. No flush and no bubble. fwd*_sel hold.
//   2) ex_branch_taken: flush_front = 1 and bubble_ex = 1. Overrides load-use and an
//      illegal in ID, because that instruction is wrong-path.
//   3) illegal in ID: flush_front = 1, bubble_ex = 1, enter DRAIN.
//   4) Load-use: ex_valid & ex_is_load & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2)
//      with id_valid. Then stall_front = 1 and bubble_ex = 1 for exactly one cycle.
//      The following cycle the hazard is resolved through WB forwarding.
// - DRAIN: stall_front = 1 and bubble_ex = 1 every cycle. The counter increments only
//   when !mem_busy; while mem_busy, stall_back = 1 and the counter holds.
// - REDIRECT: trap_redirect = 1, trap_pc = TRAP_VECTOR, flush_front = 1, bubble_ex = 1.
//   Counter clears.
// - Forwarding is computed at ID from the EX and MEM stage state. It is registered on
//   each cycle that is not a stall_front hold and not mem_busy:
//   - fwdN_sel = MEM if ex_valid & ex_write_reg & ex_rd == rsN & rsN != 0.
//   - else WB if mem_valid & mem_write_reg & mem_rd == rsN & rsN != 0.
//   - else REG.
//   - EX wins over MEM when both match.
// - fwd*_sel register REG on any cycle bubble_ex = 1.
// - x0 is never forwarded and never causes a stall.
// - No outputs change while mem_busy, except stall_front and stall_back.
// STRUCTURE
// - types.sv gets fwd_sel_t {FWD_REG, FWD_MEM, FWD_WB} and hz_state_t {RUN, DRAIN, REDIRECT}.
// - Sub-module forward_detect: combinational rs/rd compare. Instanced twice, once for rs1
//   and once for rs2. It returns fwd_sel_t and a load-use hit flag.
// - Counter width: $clog2(DRAIN_CYCLES+1).
// TESTING
// - Load-use: ex = lw x5 (ex_is_load = 1, ex_rd = 5), id_rs1 = 5.
//   -> stall_front = 1 and bubble_ex = 1 for 1 cycle; next cycle fwd1_sel = WB.
// - Back-to-back ALU: ex_rd = 3 with ex_write_reg = 1, id_rs2 = 3.
//   -> no stall; next cycle fwd2_sel = MEM.
// - Double match: ex_rd = mem_rd = 7, id_rs1 = 7.
//   -> fwd1_sel = MEM. With id_rs1 = 0 and ex_rd = 0 -> REG and no stall.
// - Branch beats illegal: ex_branch_taken = 1 and id_illegal = 1 in the same cycle.
//   -> flush_front = 1, state stays RUN, no trap_redirect.
// - Trap with DRAIN_CYCLES = 2 and no stalls: illegal in ID at cycle N.
//   -> DRAIN at N+1 and N+2; trap_redirect = 1 with trap_pc = 32'h10 at N+3 only.
//   With mem_busy = 1 at N+2, the redirect moves to N+4.
// - Reset asserted in DRAIN. -> next cycle RUN, all outputs 0, no trap_redirect ever.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and sequencer states.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_controller_forward_detect.sv
// Combinational source/destination compare for one ID source operand.
// Returns the forwarding select and whether the operand hits an in-flight load.
module forward_detect
  import hazard_controller_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       ex_valid,
  input  logic       ex_write_reg,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic       mem_valid,
  input  logic       mem_write_reg,
  input  logic [4:0] mem_rd,
  output fwd_sel_t   sel,
  output logic       load_use
);

  logic rs_nz;
  logic ex_hit;
  logic mem_hit;

  // x0 is hard-wired zero, so it never forwards and never stalls.
  assign rs_nz    = (rs != 5'd0);
  assign ex_hit   = ex_valid && ex_write_reg && (ex_rd == rs) && rs_nz;
  assign mem_hit  = mem_valid && mem_write_reg && (mem_rd == rs) && rs_nz;
  assign load_use = ex_valid && ex_is_load && (ex_rd == rs) && rs_nz;

  always_comb begin
    sel = FWD_REG;
    if (ex_hit) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage core: stall/bubble/flush control, registered
// operand-forwarding selects, and the illegal-instruction drain-then-redirect trap.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_illegal,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_write_reg,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_valid,
  input  logic        mem_write_reg,
  input  logic [4:0]  mem_rd,
  input  logic        mem_busy,
  output logic        stall_front,
  output logic        stall_back,
  output logic        bubble_ex,
  output logic        flush_front,
  output logic [1:0]  fwd1_sel,
  output logic [1:0]  fwd2_sel,
  output logic        trap_redirect,
  output logic [31:0] trap_pc
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fwd_sel_t         fwd1_q, fwd1_d;
  fwd_sel_t         fwd2_q, fwd2_d;
  logic             post_rst_q;

  fwd_sel_t det1_sel, det2_sel;
  logic     det1_lu, det2_lu;
  logic     quiet;
  logic     load_use;

  forward_detect u_fwd_rs1 (
    .rs            (id_rs1),
    .ex_valid      (ex_valid),
    .ex_write_reg  (ex_write_reg),
    .ex_is_load    (ex_is_load),
    .ex_rd         (ex_rd),
    .mem_valid     (mem_valid),
    .mem_write_reg (mem_write_reg),
    .mem_rd        (mem_rd),
    .sel           (det1_sel),
    .load_use      (det1_lu)
  );

  forward_detect u_fwd_rs2 (
    .rs            (id_rs2),
    .ex_valid      (ex_valid),
    .ex_write_reg  (ex_write_reg),
    .ex_is_load    (ex_is_load),
    .ex_rd         (ex_rd),
    .mem_valid     (mem_valid),
    .mem_write_reg (mem_write_reg),
    .mem_rd        (mem_rd),
    .sel           (det2_sel),
    .load_use      (det2_lu)
  );

  // The cycle in reset and the one right after it are held completely quiet.
  assign quiet    = reset || post_rst_q;
  assign load_use = id_valid && (det1_lu || det2_lu);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fwd1_d        = fwd1_q;
    fwd2_d        = fwd2_q;
    stall_front   = 1'b0;
    stall_back    = 1'b0;
    bubble_ex     = 1'b0;
    flush_front   = 1'b0;
    trap_redirect = 1'b0;
    if (!quiet) begin
      unique case (state_q)
        RUN: begin
          if (mem_busy) begin
            stall_front = 1'b1;
            stall_back  = 1'b1;
          end else if (ex_branch_taken) begin
            flush_front = 1'b1;
            bubble_ex   = 1'b1;
          end else if (id_illegal && id_valid) begin
            flush_front = 1'b1;
            bubble_ex   = 1'b1;
            cnt_d       = '0;
            state_d     = DRAIN;
          end else if (load_use) begin
            stall_front = 1'b1;
            bubble_ex   = 1'b1;
          end
        end
        DRAIN: begin
          stall_front = 1'b1;
          bubble_ex   = 1'b1;
          if (mem_busy) begin
            stall_back = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = REDIRECT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REDIRECT: begin
          trap_redirect = 1'b1;
          flush_front   = 1'b1;
          bubble_ex     = 1'b1;
          cnt_d         = '0;
          state_d       = RUN;
        end
        default: state_d = RUN;
      endcase

      // A bubble entering EX carries no operands, so its selects are REG.
      if (!mem_busy) begin
        if (bubble_ex) begin
          fwd1_d = FWD_REG;
          fwd2_d = FWD_REG;
        end else if (!stall_front) begin
          fwd1_d = det1_sel;
          fwd2_d = det2_sel;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      fwd1_q     <= FWD_REG;
      fwd2_q     <= FWD_REG;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fwd1_q     <= fwd1_d;
      fwd2_q     <= fwd2_d;
      post_rst_q <= 1'b0;
    end
  end

  assign fwd1_sel = fwd1_q;
  assign fwd2_sel = fwd2_q;
  assign trap_pc  = trap_redirect ? TRAP_VECTOR : '0;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller: forwarding, load-use, branch
// priority, trap drain/redirect timing, mem_busy holds and reset abort.
module tb_hazard_controller;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_illegal;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_write_reg, ex_is_load, ex_branch_taken;
  logic        mem_valid, mem_write_reg;
  logic [4:0]  mem_rd;
  logic        mem_busy;
  logic        stall_front, stall_back, bubble_ex, flush_front;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic        trap_redirect;
  logic [31:0] trap_pc;

  int tests;
  int failed;

  localparam logic [1:0] REG = 2'd0;
  localparam logic [1:0] MEM = 2'd1;
  localparam logic [1:0] WB  = 2'd2;

  hazard_controller #(
    .DRAIN_CYCLES (2),
    .TRAP_VECTOR  (32'h0000_0010)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_illegal      (id_illegal),
    .ex_valid        (ex_valid),
    .ex_rd           (ex_rd),
    .ex_write_reg    (ex_write_reg),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_valid       (mem_valid),
    .mem_write_reg   (mem_write_reg),
    .mem_rd          (mem_rd),
    .mem_busy        (mem_busy),
    .stall_front     (stall_front),
    .stall_back      (stall_back),
    .bubble_ex       (bubble_ex),
    .flush_front     (flush_front),
    .fwd1_sel        (fwd1_sel),
    .fwd2_sel        (fwd2_sel),
    .trap_redirect   (trap_redirect),
    .trap_pc         (trap_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the five 1-bit controls: {stall_front, stall_back, bubble_ex, flush_front, trap_redirect}.
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, stall_front, stall_back, bubble_ex, flush_front, trap_redirect}, {27'd0, exp});
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_illegal = 0;
    ex_valid = 0; ex_rd = 0; ex_write_reg = 0; ex_is_load = 0; ex_branch_taken = 0;
    mem_valid = 0; mem_write_reg = 0; mem_rd = 0; mem_busy = 0;
  endtask

  // Advance one cycle; inputs are driven 1 time unit after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    idle();

    // Reset: controls stay 0 even with a trap/branch/load-use pattern present.
    cyc();
    id_valid = 1; id_illegal = 1; ex_branch_taken = 1;
    ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_rs1 = 5;
    settle();
    chk_ctl("reset_ctl", 5'b00000);
    chk("reset_pc", trap_pc, 32'h0);
    cyc();
    chk("reset_fwd1", {30'd0, fwd1_sel}, {30'd0, REG});
    chk("reset_fwd2", {30'd0, fwd2_sel}, {30'd0, REG});

    // First cycle after reset: still quiet despite a load-use pattern.
    reset = 1'b0;
    idle();
    id_valid = 1; id_rs1 = 5; ex_valid = 1; ex_is_load = 1; ex_rd = 5;
    settle();
    chk_ctl("post_reset_ctl", 5'b00000);
    cyc();
    idle();
    settle();
    chk_ctl("run_idle", 5'b00000);

    // Load-use on rs1: one-cycle stall + bubble, then WB forwarding.
    cyc();
    id_valid = 1; id_rs1 = 5;
    ex_valid = 1; ex_is_load = 1; ex_write_reg = 1; ex_rd = 5;
    settle();
    chk_ctl("lu_stall", 5'b10100);
    cyc();
    chk("lu_fwd1_bubble", {30'd0, fwd1_sel}, {30'd0, REG});
    ex_valid = 0; ex_is_load = 0; ex_write_reg = 0; ex_rd = 0;
    mem_valid = 1; mem_write_reg = 1; mem_rd = 5;
    settle();
    chk_ctl("lu_resolved", 5'b00000);
    cyc();
    chk("lu_fwd1_wb", {30'd0, fwd1_sel}, {30'd0, WB});
    chk("lu_fwd2_reg", {30'd0, fwd2_sel}, {30'd0, REG});

    // Load-use pattern with id_valid = 0 does not stall.
    idle();
    id_rs1 = 5; ex_valid = 1; ex_is_load = 1; ex_write_reg = 1; ex_rd = 5;
    settle();
    chk_ctl("lu_id_invalid", 5'b00000);

    // Back-to-back ALU on rs2: no stall, MEM forwarding.
    cyc();
    idle();
    id_valid = 1; id_rs2 = 3; ex_valid = 1; ex_write_reg = 1; ex_rd = 3;
    settle();
    chk_ctl("alu_nostall", 5'b00000);
    cyc();
    chk("alu_fwd2_mem", {30'd0, fwd2_sel}, {30'd0, MEM});

    // Double match: EX wins over MEM.
    idle();
    id_valid = 1; id_rs1 = 7;
    ex_valid = 1; ex_write_reg = 1; ex_rd = 7;
    mem_valid = 1; mem_write_reg = 1; mem_rd = 7;
    cyc();
    chk("dbl_fwd1_mem", {30'd0, fwd1_sel}, {30'd0, MEM});

    // mem_busy holds everything: only stalls assert, selects keep MEM.
    ex_valid = 0; ex_branch_taken = 1; mem_busy = 1;
    settle();
    chk_ctl("busy_hold_ctl", 5'b11000);
    cyc();
    chk("busy_hold_fwd1", {30'd0, fwd1_sel}, {30'd0, MEM});

    // x0 never forwards or stalls.
    idle();
    id_valid = 1; id_rs1 = 0; ex_valid = 1; ex_is_load = 1; ex_write_reg = 1; ex_rd = 0;
    settle();
    chk_ctl("x0_nostall", 5'b00000);
    cyc();
    chk("x0_fwd1_reg", {30'd0, fwd1_sel}, {30'd0, REG});

    // Branch beats illegal and load-use; state stays RUN.
    idle();
    id_valid = 1; id_illegal = 1; ex_branch_taken = 1;
    id_rs1 = 9; ex_valid = 1; ex_is_load = 1; ex_rd = 9;
    settle();
    chk_ctl("br_flush", 5'b00110);
    cyc();
    idle();
    settle();
    chk_ctl("br_still_run", 5'b00000);
    cyc();
    settle();
    chk_ctl("br_no_trap", 5'b00000);

    // Trap, no stalls: illegal at N, drain N+1/N+2, redirect N+3.
    cyc();
    id_valid = 1; id_illegal = 1;
    settle();
    chk_ctl("trap_n", 5'b00110);
    cyc();
    idle();
    settle();
    chk_ctl("trap_n1_drain", 5'b10100);
    cyc();
    settle();
    chk_ctl("trap_n2_drain", 5'b10100);
    cyc();
    settle();
    chk_ctl("trap_n3_redirect", 5'b00111);
    chk("trap_n3_pc", trap_pc, 32'h10);
    cyc();
    settle();
    chk_ctl("trap_n4_run", 5'b00000);
    chk("trap_n4_pc", trap_pc, 32'h0);

    // Trap with mem_busy at N+2: redirect slips to N+4.
    cyc();
    id_valid = 1; id_illegal = 1;
    settle();
    chk_ctl("tb_n", 5'b00110);
    cyc();
    idle();
    settle();
    chk_ctl("tb_n1_drain", 5'b10100);
    cyc();
    mem_busy = 1;
    settle();
    chk_ctl("tb_n2_busy", 5'b11100);
    cyc();
    mem_busy = 0;
    settle();
    chk_ctl("tb_n3_drain", 5'b10100);
    cyc();
    settle();
    chk_ctl("tb_n4_redirect", 5'b00111);
    chk("tb_n4_pc", trap_pc, 32'h10);
    cyc();
    settle();
    chk_ctl("tb_n5_run", 5'b00000);

    // Reset asserted in DRAIN aborts the trap.
    cyc();
    id_valid = 1; id_illegal = 1;
    settle();
    chk_ctl("rd_n", 5'b00110);
    cyc();
    idle();
    settle();
    chk_ctl("rd_n1_drain", 5'b10100);
    cyc();
    reset = 1'b1;
    settle();
    chk_ctl("rd_in_reset", 5'b00000);
    cyc();
    reset = 1'b0;
    settle();
    chk_ctl("rd_after_reset", 5'b00000);
    for (int i = 0; i < 4; i++) begin
      cyc();
      settle();
      chk_ctl("rd_no_trap", 5'b00000);
      chk("rd_no_trap_pc", trap_pc, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
